root_dispatch: RTL and testbench



---
 rtl/root_dispatch.sv | 179 +++++++++++++++++
 tb/tb_root_dispatch.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/root_dispatch.sv
// Request scheduler for the fixed-point root engine: tagged request FIFO, one-in-flight issue FSM, tagged response port.
// Optional ROOT_DISPATCH_TIMEOUT_EN adds a WAIT watchdog that answers with rsp_err after TIMEOUT cycles.
module root_dispatch #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [9:0]       req_radicand,
  input  logic [2:0]       req_exp,
  input  logic [TAG_W-1:0] req_tag,
  output logic             root_in_valid,
  output logic [9:0]       root_in_data_1,
  output logic [2:0]       root_in_data_2,
  input  logic             root_out_valid,
  input  logic [19:0]      root_out_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [19:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e           state_q, state_d;
  logic [9:0]       fifo_rad_q [DEPTH];
  logic [2:0]       fifo_exp_q [DEPTH];
  logic [TAG_W-1:0] fifo_tag_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push, pop;

  logic [9:0]       op_rad_q, op_rad_d;
  logic [2:0]       op_exp_q, op_exp_d;
  logic [19:0]      rsp_data_q, rsp_data_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic             rsp_err_q, rsp_err_d;

  logic [2:0]       head_exp;
  logic [TAG_W-1:0] head_tag;

  assign req_ready = (count_q != FULL_CNT);
  assign push      = req_valid && req_ready;
  assign head_exp  = fifo_exp_q[rd_ptr_q];
  assign head_tag  = fifo_tag_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: storage is cleared along with the pointers so every flop comes out of reset known.
      for (int i = 0; i < DEPTH; i++) begin
        fifo_rad_q[i] <= '0;
        fifo_exp_q[i] <= '0;
        fifo_tag_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_rad_q[wr_ptr_q] <= req_radicand;
        fifo_exp_q[wr_ptr_q] <= req_exp;
        fifo_tag_q[wr_ptr_q] <= req_tag;
        wr_ptr_q             <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

`ifdef ROOT_DISPATCH_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
`endif

  always_comb begin
    // NOTE: every _d gets its hold value first, so no branch can infer a latch.
    state_d    = state_q;
    pop        = 1'b0;
    op_rad_d   = op_rad_q;
    op_exp_d   = op_exp_q;
    rsp_data_d = rsp_data_q;
    rsp_tag_d  = rsp_tag_q;
    rsp_err_d  = rsp_err_q;
`ifdef ROOT_DISPATCH_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        // A lingering second strobe cycle must drain before the next start.
        if ((count_q != '0) && !root_out_valid) begin
          state_d  = ISSUE;
          op_rad_d = fifo_rad_q[rd_ptr_q];
          op_exp_d = head_exp;
        end
      end
      ISSUE: begin
`ifdef ROOT_DISPATCH_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
        if (head_exp == '0) begin
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
          rsp_tag_d  = head_tag;
          pop        = 1'b1;
          state_d    = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (root_out_valid) begin
          rsp_err_d  = 1'b0;
          rsp_data_d = root_out_data;
          rsp_tag_d  = head_tag;
          pop        = 1'b1;
          state_d    = RESP;
        end
`ifdef ROOT_DISPATCH_TIMEOUT_EN
        else if (wait_cnt_q == TO_LAST) begin
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
          rsp_tag_d  = head_tag;
          pop        = 1'b1;
          state_d    = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_rad_q   <= '0;
      op_exp_q   <= '0;
      rsp_data_q <= '0;
      rsp_tag_q  <= '0;
      rsp_err_q  <= 1'b0;
`ifdef ROOT_DISPATCH_TIMEOUT_EN
      wait_cnt_q <= '0;
`endif
    end else begin
      // NOTE: clocked state uses <= only, so every flop samples pre-edge values.
      state_q    <= state_d;
      op_rad_q   <= op_rad_d;
      op_exp_q   <= op_exp_d;
      rsp_data_q <= rsp_data_d;
      rsp_tag_q  <= rsp_tag_d;
      rsp_err_q  <= rsp_err_d;
`ifdef ROOT_DISPATCH_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
`endif
    end
  end

  assign root_in_valid  = (state_q == ISSUE) && (op_exp_q != '0);
  assign root_in_data_1 = op_rad_q;
  assign root_in_data_2 = op_exp_q;
  assign rsp_valid      = (state_q == RESP);
  assign rsp_data       = rsp_data_q;
  assign rsp_tag        = rsp_tag_q;
  assign rsp_err        = rsp_err_q;

endmodule

// File: tb/tb_root_dispatch.sv
// Bench for root_dispatch: transaction-level model plus a reactive engine model, per-cycle comparison, directed and random traffic.
module tb_root_dispatch;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
`ifdef ROOT_DISPATCH_TIMEOUT_EN
  localparam int TB_TIMEOUT = 20;
  localparam bit TO_EN      = 1'b1;
`else
  localparam int TB_TIMEOUT = 1023;
  localparam bit TO_EN      = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid, req_ready;
  logic [9:0]       req_radicand;
  logic [2:0]       req_exp;
  logic [TAG_W-1:0] req_tag;
  logic             root_in_valid;
  logic [9:0]       root_in_data_1;
  logic [2:0]       root_in_data_2;
  logic             root_out_valid;
  logic [19:0]      root_out_data;
  logic             rsp_valid, rsp_ready;
  logic [19:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;

  root_dispatch #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_radicand(req_radicand), .req_exp(req_exp), .req_tag(req_tag),
    .root_in_valid(root_in_valid), .root_in_data_1(root_in_data_1), .root_in_data_2(root_in_data_2),
    .root_out_valid(root_out_valid), .root_out_data(root_out_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [9:0] rad; logic [2:0] ex; logic [TAG_W-1:0] tag; } req_t;
  typedef struct { logic [19:0] data; logic [TAG_W-1:0] tag; logic err; } rsp_t;

  int n_pass = 0, n_total = 0;

  // Transaction-level model: queued requests, one request in some phase of service.
  req_t             mq[$];
  bit               m_issue, m_wait, m_resp, m_push_acc;
  int               m_wait_cycles;
  logic [9:0]       m_op_rad;
  logic [2:0]       m_op_exp;
  rsp_t             m_rsp;

  // Observations from the DUT.
  rsp_t got_q[$];
  int   cyc = 0, issues = 0, last_issue_cyc = 0, rise_cyc = 0;
  bit   prev_rsp_valid;

  // Engine model.
  int          eng_delay, eng_hold, eng_len, force_delay, force_len;
  bit          eng_stall;
  logic [19:0] eng_res;
  logic [19:0] fixed_res[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    mq.delete();
    m_issue = 0; m_wait = 0; m_resp = 0; m_push_acc = 0; m_wait_cycles = 0;
    m_op_rad = '0; m_op_exp = '0;
    m_rsp = '{data: '0, tag: '0, err: 1'b0};
    prev_rsp_valid = 0;
    eng_delay = 0; eng_hold = 0; eng_len = 1; eng_stall = 0; eng_res = '0;
    force_delay = 0; force_len = 0; fixed_res.delete();
    root_out_valid = 0; root_out_data = '0;
  endtask

  task automatic load_rsp(input logic [19:0] d, input logic e);
    m_rsp = '{data: d, tag: mq[0].tag, err: e};
    void'(mq.pop_front());
    m_resp = 1;
  endtask

  // Advance the model across one rising edge using the inputs the bench was driving.
  task automatic model_update();
    bit acc;
    acc = req_valid && (mq.size() < DEPTH);
    if (m_resp) begin
      if (rsp_ready) m_resp = 0;
    end else if (m_issue) begin
      m_issue = 0;
      if (m_op_exp == 0) load_rsp('0, 1'b1);
      else begin m_wait = 1; m_wait_cycles = 0; end
    end else if (m_wait) begin
      m_wait_cycles++;
      if (root_out_valid) begin m_wait = 0; load_rsp(root_out_data, 1'b0); end
      else if (TO_EN && m_wait_cycles >= TB_TIMEOUT) begin m_wait = 0; load_rsp('0, 1'b1); end
    end else if (mq.size() > 0 && !root_out_valid) begin
      m_issue  = 1;
      m_op_rad = mq[0].rad;
      m_op_exp = mq[0].ex;
    end
    if (acc) mq.push_back('{rad: req_radicand, ex: req_exp, tag: req_tag});
    m_push_acc = acc;
  endtask

  task automatic compare();
    cyc++;
    check("req_ready", req_ready, mq.size() < DEPTH);
    check("root_in_valid", root_in_valid, m_issue && (m_op_exp != 0));
    check("root_in_data_1", root_in_data_1, m_op_rad);
    check("root_in_data_2", root_in_data_2, m_op_exp);
    check("rsp_valid", rsp_valid, m_resp);
    if (m_resp) begin
      check("rsp_data", rsp_data, m_rsp.data);
      check("rsp_tag", rsp_tag, m_rsp.tag);
      check("rsp_err", rsp_err, m_rsp.err);
    end
    if (root_in_valid) begin
      issues++;
      last_issue_cyc = cyc;
      check("issue_during_strobe", root_out_valid, 0);
    end
    if (rsp_valid && !prev_rsp_valid) rise_cyc = cyc;
    prev_rsp_valid = rsp_valid;
    if (rsp_valid && rsp_ready) got_q.push_back('{data: rsp_data, tag: rsp_tag, err: rsp_err});
  endtask

  task automatic engine_step();
    if (eng_hold > 0) begin
      eng_hold--;
      if (eng_hold == 0) root_out_valid = 0;
    end
    if (eng_delay > 0 && !eng_stall) begin
      eng_delay--;
      if (eng_delay == 0) begin
        root_out_valid = 1;
        root_out_data  = eng_res;
        eng_hold       = eng_len;
      end
    end
    if (root_in_valid) begin
      eng_delay = (force_delay > 0) ? force_delay : int'($urandom_range(1, 6));
      eng_len   = (force_len > 0) ? force_len : int'($urandom_range(1, 2));
      eng_res   = (fixed_res.size() > 0) ? fixed_res.pop_front() : 20'($urandom);
    end
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic cycle();
    @(negedge clk);
    compare();
    engine_step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    req_valid = 0; req_radicand = '0; req_exp = '0; req_tag = '0; rsp_ready = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [9:0] r, input logic [2:0] e, input logic [TAG_W-1:0] t);
    int n = 0;
    req_radicand = r; req_exp = e; req_tag = t; req_valid = 1;
    do begin cycle(); n++; end while (!m_push_acc && n < 60);
    req_valid = 0;
    check("push_accept", m_push_acc, 1);
  endtask

  task automatic wait_model_resp(input int budget);
    int n = 0;
    while (!m_resp && n < budget) begin cycle(); n++; end
    check("wait_rsp_bound", n < budget, 1);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    req_valid = 0; rsp_ready = 1;
    while ((mq.size() > 0 || m_issue || m_wait || m_resp || root_out_valid) && n < budget) begin
      cycle(); n++;
    end
    check("drain_bound", n < budget, 1);
  endtask

  initial begin
    int i0, n;
    rst_n = 0;
    do_reset();

    // Reset values, pinned by hand.
    check("rst_req_ready", req_ready, 1);
    check("rst_root_in_valid", root_in_valid, 0);
    check("rst_data_1", root_in_data_1, 0);
    check("rst_data_2", root_in_data_2, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_tag", rsp_tag, 0);
    check("rst_rsp_err", rsp_err, 0);

    // Single request, square root of 16.
    got_q.delete(); i0 = issues;
    fixed_res.push_back(20'h01000); force_delay = 3; force_len = 1; rsp_ready = 1;
    push(10'd16, 3'd2, 4'd3);
    drain(100);
    check("t1_issue_count", issues - i0, 1);
    check("t1_rsp_count", got_q.size(), 1);
    if (got_q.size() == 1) begin
      check("t1_rsp_data", got_q[0].data, 20'h01000);
      check("t1_rsp_tag", got_q[0].tag, 3);
      check("t1_rsp_err", got_q[0].err, 0);
    end

    // Two back-to-back requests with a 2-cycle engine strobe each.
    got_q.delete(); i0 = issues;
    fixed_res.push_back(20'h00C00); fixed_res.push_back(20'h04000); force_delay = 2; force_len = 2;
    push(10'd27, 3'd3, 4'd5);
    push(10'd16, 3'd1, 4'd6);
    drain(100);
    check("t2_issue_count", issues - i0, 2);
    check("t2_rsp_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("t2_rsp0_data", got_q[0].data, 20'h00C00);
      check("t2_rsp0_tag", got_q[0].tag, 5);
      check("t2_rsp1_data", got_q[1].data, 20'h04000);
      check("t2_rsp1_tag", got_q[1].tag, 6);
    end

    // Exponent 0 is rejected without touching the engine.
    got_q.delete(); i0 = issues;
    push(10'd8, 3'd0, 4'd7);
    drain(100);
    check("t3_issue_count", issues - i0, 0);
    check("t3_rsp_count", got_q.size(), 1);
    if (got_q.size() == 1) begin
      check("t3_rsp_err", got_q[0].err, 1);
      check("t3_rsp_data", got_q[0].data, 0);
      check("t3_rsp_tag", got_q[0].tag, 7);
    end

    // Fill the FIFO behind a stalled engine.
    got_q.delete(); force_delay = 2; force_len = 1; eng_stall = 1; rsp_ready = 1;
    for (int k = 0; k < 4; k++) push(10'(100 + k), 3'd2, 4'(8 + k));
    req_radicand = 10'd200; req_exp = 3'd2; req_tag = 4'd12; req_valid = 1;
    repeat (3) cycle();
    check("t4_full_ready", req_ready, 0);
    eng_stall = 0;
    n = 0;
    while (!rsp_valid && n < 50) begin cycle(); n++; end
    check("t4_ready_after_pop", req_ready, 1);
    n = 0;
    do begin cycle(); n++; end while (!m_push_acc && n < 50);
    req_valid = 0;
    check("t4_fifth_accepted", m_push_acc, 1);
    drain(200);
    check("t4_rsp_count", got_q.size(), 5);
    for (int k = 0; k < 5; k++)
      if (k < got_q.size()) check("t4_order_tag", got_q[k].tag, 8 + k);

    // Response back-pressure: outputs stable, no new issue meanwhile.
    fixed_res.push_back(20'h00ABC); rsp_ready = 0;
    push(10'd200, 3'd4, 4'd13);
    push(10'd50, 3'd2, 4'd14);
    wait_model_resp(50);
    i0 = issues;
    repeat (10) cycle();
    check("t5_rsp_valid_held", rsp_valid, 1);
    check("t5_rsp_tag_held", rsp_tag, 13);
    check("t5_rsp_data_held", rsp_data, 20'h00ABC);
    check("t5_no_issue", issues - i0, 0);
    drain(100);

    // Asynchronous reset in the middle of WAIT.
    eng_stall = 1;
    push(10'd77, 3'd5, 4'd1);
    repeat (3) cycle();
    #2;
    rst_n = 0;
    #1;
    check("t6_req_ready", req_ready, 1);
    check("t6_root_in_valid", root_in_valid, 0);
    check("t6_data_1", root_in_data_1, 0);
    check("t6_data_2", root_in_data_2, 0);
    check("t6_rsp_valid", rsp_valid, 0);
    check("t6_rsp_data", rsp_data, 0);
    check("t6_rsp_tag", rsp_tag, 0);
    check("t6_rsp_err", rsp_err, 0);
    do_reset();

    // Random traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      if (!req_valid || m_push_acc) begin
        req_valid    = ($urandom_range(0, 2) != 0);
        req_radicand = 10'($urandom);
        req_exp      = 3'($urandom_range(0, 7));
        req_tag      = 4'($urandom);
      end
      rsp_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end
    drain(300);

`ifdef ROOT_DISPATCH_TIMEOUT_EN
    // Engine never answers: watchdog response 20 cycles into WAIT.
    got_q.delete(); eng_stall = 1; rsp_ready = 0;
    push(10'd100, 3'd3, 4'd9);
    wait_model_resp(80);
    cycle();
    check("t7_timeout_latency", rise_cyc - last_issue_cyc, TB_TIMEOUT + 1);
    check("t7_rsp_err", rsp_err, 1);
    check("t7_rsp_data", rsp_data, 0);
    check("t7_rsp_tag", rsp_tag, 9);
    eng_stall = 0; rsp_ready = 1;
    repeat (10) cycle();
    drain(100);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
